// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display.
// Stores one 3-bit value and one blank flag per digit. Lights one digit at a
// time, with an all-dark gap between digits, and feeds the value of the
// current digit to a single shared decoder.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned DEAD       = 16,
    parameter int unsigned AW         = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [2:0]            wr_data,
    input  logic                  wr_blank,
    output logic [2:0]            bcd,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic                  frame_done
);

    localparam int unsigned CntMax = (PRESCALE > DEAD) ? PRESCALE : DEAD;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [CW-1:0] ScanLast = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] DeadLast = CW'(DEAD - 1);
    localparam logic [AW-1:0] IdxLast  = AW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        StOff,
        StGap,
        StScan
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              val_q [NUM_DIGITS];
    logic [2:0]              val_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [2:0]              bcd_d;
    logic [NUM_DIGITS-1:0]   digit_en_n_d;
    logic                    frame_done_d;
    logic                    wr_fire;

    assign wr_fire = wr_valid & wr_ready;

    // Next-state: digit storage, scan FSM, and the outputs derived from them.
    // Outputs are computed from the next state so a write shows up on the
    // cycle right after it is accepted.
    always_comb begin
        val_d        = val_q;
        blank_d      = blank_q;
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;

        // Out-of-range addresses are accepted but have no effect.
        if (wr_fire && (32'(wr_addr) < NUM_DIGITS)) begin
            val_d[wr_addr]   = wr_data;
            blank_d[wr_addr] = wr_blank;
        end

        if (!en) begin
            state_d = StOff;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StGap;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                StGap: begin
                    if (cnt_q == DeadLast) begin
                        state_d = StScan;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StScan: begin
                    if (cnt_q == ScanLast) begin
                        state_d = StGap;
                        cnt_d   = '0;
                        if (idx_q == IdxLast) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = StOff;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Value is presented through the gap so the decoder settles before lighting.
        bcd_d        = val_d[idx_d];
        digit_en_n_d = '1;
        if ((state_d == StScan) && !blank_d[idx_d]) begin
            digit_en_n_d[idx_d] = 1'b0;
        end
    end

    // State and registered outputs; reset darkens the display immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StGap;
            idx_q      <= '0;
            cnt_q      <= '0;
            val_q      <= '{default: '0};
            blank_q    <= '1;
            bcd        <= '0;
            digit_en_n <= '1;
            wr_ready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            val_q      <= val_d;
            blank_q    <= blank_d;
            bcd        <= bcd_d;
            digit_en_n <= digit_en_n_d;
            wr_ready   <= 1'b1;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, PRESCALE=4, DEAD=1.
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [2:0] wr_data;
    logic       wr_blank;
    logic [2:0] bcd;
    logic [3:0] digit_en_n;
    logic       frame_done;

    int n_total = 0;
    int n_bad   = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS (4),
        .PRESCALE   (4),
        .DEAD       (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_blank   (wr_blank),
        .bcd        (bcd),
        .digit_en_n (digit_en_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [2:0] d, input logic b);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_blank = b;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_sel(input logic [3:0] pat, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (digit_en_n === pat) found = 1'b1;
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    logic [2:0] vals [4];

    initial begin
        vals[0] = 3'd5;
        vals[1] = 3'd2;
        vals[2] = 3'd7;
        vals[3] = 3'd1;

        reset    = 1'b1;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: reset values, ready timing, all-blank scan stays dark
        check_eq("rst_sel", 32'(digit_en_n), 32'hF);
        check_eq("rst_bcd", 32'(bcd), 32'd0);
        check_eq("rst_ready", 32'(wr_ready), 32'd0);
        check_eq("rst_frame", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("ready_pre_edge", 32'(wr_ready), 32'd0);
        step();
        check_eq("ready_post_edge", 32'(wr_ready), 32'd1);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("blank_dark", 32'(digit_en_n), 32'hF);
        end

        // 2: write 5,2,7,1 while off, then scan two full frames
        en = 1'b0;
        step();
        for (int i = 0; i < 4; i++) write(2'(i), vals[i], 1'b0);
        check_eq("off_dark", 32'(digit_en_n), 32'hF);
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            int p;
            int d;
            logic [3:0] exp_sel;
            step();
            p = c % 5;
            d = (c / 5) % 4;
            exp_sel = (p == 0) ? 4'hF : ~(4'b0001 << d);
            check_eq("scan_sel", 32'(digit_en_n), 32'(exp_sel));
            check_eq("scan_bcd", 32'(bcd), 32'(vals[d]));
            check_eq("scan_frame", 32'(frame_done), 32'((p == 0 && d == 0 && c > 0) ? 1 : 0));
        end

        // 3: rewrite digit1 mid-scan; dwell unchanged; then blank it
        wait_sel(4'b1101, "wait_d1");
        write(2'd1, 3'd3, 1'b0);
        check_eq("wr_live_bcd", 32'(bcd), 32'd3);
        check_eq("wr_live_sel", 32'(digit_en_n), 32'b1101);
        step();
        check_eq("dwell_2", 32'(digit_en_n), 32'b1101);
        step();
        check_eq("dwell_3", 32'(digit_en_n), 32'b1101);
        step();
        check_eq("dwell_end_sel", 32'(digit_en_n), 32'hF);
        check_eq("dwell_end_bcd", 32'(bcd), 32'd7);
        wait_sel(4'b1101, "wait_d1_again");
        write(2'd1, 3'd3, 1'b1);
        check_eq("blank_live", 32'(digit_en_n), 32'hF);
        write(2'd1, 3'd2, 1'b0);
        check_eq("unblank_sel", 32'(digit_en_n), 32'b1101);
        check_eq("unblank_bcd", 32'(bcd), 32'd2);

        // 4: disable during digit2, re-enable restarts at digit0
        wait_sel(4'b1011, "wait_d2");
        en = 1'b0;
        step();
        check_eq("dis_sel", 32'(digit_en_n), 32'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("off_hold", 32'(digit_en_n), 32'hF);
        end
        en = 1'b1;
        step();
        check_eq("reen_gap_sel", 32'(digit_en_n), 32'hF);
        check_eq("reen_gap_bcd", 32'(bcd), 32'd5);
        step();
        check_eq("reen_d0_sel", 32'(digit_en_n), 32'b1110);
        check_eq("reen_d0_bcd", 32'(bcd), 32'd5);

        // 5: write digit3 on the same edge idx advances 2->3
        wait_sel(4'b1011, "wait_d2_b");
        step();
        step();
        step();
        check_eq("d2_last", 32'(digit_en_n), 32'b1011);
        write(2'd3, 3'd6, 1'b0);
        check_eq("adv_gap_sel", 32'(digit_en_n), 32'hF);
        check_eq("adv_gap_bcd", 32'(bcd), 32'd6);
        step();
        check_eq("adv_d3_sel", 32'(digit_en_n), 32'b0111);
        check_eq("adv_d3_bcd", 32'(bcd), 32'd6);

        // 6: async reset mid-scan, then everything blank until rewritten
        wait_sel(4'b1110, "wait_d0");
        #2;
        reset = 1'b1;
        #1;
        check_eq("areset_sel", 32'(digit_en_n), 32'hF);
        check_eq("areset_bcd", 32'(bcd), 32'd0);
        check_eq("areset_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_eq("post_rst_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 25; i++) begin
            step();
            check_eq("post_rst_dark", 32'(digit_en_n), 32'hF);
            check_eq("post_rst_bcd", 32'(bcd), 32'd0);
        end
        write(2'd2, 3'd4, 1'b0);
        wait_sel(4'b1011, "wait_rewrite");
        check_eq("rewrite_bcd", 32'(bcd), 32'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
